alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/core_pkg.sv | 26 ++
 rtl/alu.sv | 37 +++
 rtl/alu_arbiter.sv | 95 +++++++++
 tb/tb_alu_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, ALU operation encoding and the
// result-slot state of the ALU arbiter.
package core_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_sel_e;

  typedef enum logic {
    ARB_EMPTY = 1'b0,
    ARB_FULL  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/alu.sv
// EX-stage ALU: purely combinational, shifts use operand2[4:0], unknown
// selections produce zero.
module alu
  import core_pkg::*;
#(
  parameter int DATA_WIDTH = core_pkg::DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  alu_sel_e              sel,
  output logic [DATA_WIDTH-1:0] result
);

  logic [4:0] shamt;
  assign shamt = operand2[4:0];

  // NOTE: every output of an always_comb gets a default first so no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    result = '0;
    case (sel)
      ALU_ADD:    result = operand1 + operand2;
      ALU_SUB:    result = operand1 - operand2;
      ALU_SLL:    result = operand1 << shamt;
      ALU_SLT:    result = {{(DATA_WIDTH-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
      ALU_SLTU:   result = {{(DATA_WIDTH-1){1'b0}}, (operand1 < operand2)};
      ALU_XOR:    result = operand1 ^ operand2;
      ALU_SRL:    result = operand1 >> shamt;
      ALU_SRA:    result = $signed(operand1) >>> shamt;
      ALU_OR:     result = operand1 | operand2;
      ALU_AND:    result = operand1 & operand2;
      ALU_PASS_B: result = operand2;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end to a single ALU with a one-entry
// registered result slot that supports consume-and-refill in the same cycle.
module alu_arbiter
  import core_pkg::*;
#(
  parameter int DATA_WIDTH = core_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,

  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic [DATA_WIDTH-1:0] req0_op1_i,
  input  logic [DATA_WIDTH-1:0] req0_op2_i,
  input  alu_sel_e              req0_sel_i,

  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic [DATA_WIDTH-1:0] req1_op1_i,
  input  logic [DATA_WIDTH-1:0] req1_op2_i,
  input  alu_sel_e              req1_sel_i,

  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_result_o,
  output logic                  rsp_id_o
);

  arb_state_e            state;
  logic                  last_grant;
  logic                  grant_id;
  logic                  slot_free;
  logic                  can_accept;
  logic                  accept;
  logic [DATA_WIDTH-1:0] alu_op1;
  logic [DATA_WIDTH-1:0] alu_op2;
  alu_sel_e              alu_sel;
  logic [DATA_WIDTH-1:0] alu_result;

  // Under contention the requester that did not win last time goes next.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      grant_id = ~last_grant;
    end else if (req1_valid_i) begin
      grant_id = 1'b1;
    end
  end

  assign slot_free  = (state == ARB_EMPTY) || rsp_ready_i;
  // rst_n gates the readies so nothing looks accepted while reset is held.
  assign can_accept = slot_free && !flush_i && rst_n;

  assign req0_ready_o = req0_valid_i && !grant_id && can_accept;
  assign req1_ready_o = req1_valid_i &&  grant_id && can_accept;
  assign accept       = req0_ready_o || req1_ready_o;

  assign alu_op1 = grant_id ? req1_op1_i : req0_op1_i;
  assign alu_op2 = grant_id ? req1_op2_i : req0_op2_i;
  assign alu_sel = grant_id ? req1_sel_i : req0_sel_i;

  alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .operand1(alu_op1),
    .operand2(alu_op2),
    .sel     (alu_sel),
    .result  (alu_result)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ARB_EMPTY;
      last_grant   <= 1'b1;
      rsp_result_o <= '0;
      rsp_id_o     <= 1'b0;
    end else if (flush_i) begin
      state      <= ARB_EMPTY;
      last_grant <= 1'b1;
    end else if (accept) begin
      state        <= ARB_FULL;
      last_grant   <= grant_id;
      rsp_result_o <= alu_result;
      rsp_id_o     <= grant_id;
    end else if (rsp_ready_i) begin
      state <= ARB_EMPTY;
    end
  end

  assign rsp_valid_o = (state == ARB_FULL);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: ALU vector table plus contention,
// backpressure, flush and asynchronous-reset sequences.
module tb_alu_arbiter;
  import core_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_op1, req0_op2;
  alu_sel_e    req0_sel;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_op1, req1_op2;
  alu_sel_e    req1_sel;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        id;
    alu_sel_e    sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  alu_arbiter #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .req0_valid_i(req0_valid),
    .req0_ready_o(req0_ready),
    .req0_op1_i  (req0_op1),
    .req0_op2_i  (req0_op2),
    .req0_sel_i  (req0_sel),
    .req1_valid_i(req1_valid),
    .req1_ready_o(req1_ready),
    .req1_op1_i  (req1_op1),
    .req1_op2_i  (req1_op2),
    .req1_sel_i  (req1_sel),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_result_o(rsp_result),
    .rsp_id_o    (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic n, input logic v, input alu_sel_e s,
                         input logic [31:0] a, input logic [31:0] b);
    if (n == 1'b0) begin
      req0_valid = v; req0_sel = s; req0_op1 = a; req0_op2 = b;
    end else begin
      req1_valid = v; req1_sel = s; req1_op1 = a; req1_op2 = b;
    end
  endtask

  // Checks readies #1 after the negedge drive, result #1 after the posedge.
  task automatic expect_grant(input string tag, input logic g,
                              input logic [31:0] exp_res);
    #1;
    check({tag, " ready0"}, {31'd0, req0_ready}, {31'd0, g == 1'b0});
    check({tag, " ready1"}, {31'd0, req1_ready}, {31'd0, g == 1'b1});
    @(posedge clk); #1;
    check({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, " rsp_id"}, {31'd0, rsp_id}, {31'd0, g});
    check({tag, " rsp_result"}, rsp_result, exp_res);
  endtask

  initial begin
    vecs[0]  = '{1'b0, ALU_ADD,    32'd5,        32'd7,        32'd12};
    vecs[1]  = '{1'b1, ALU_SUB,    32'd3,        32'd5,        32'hFFFF_FFFE};
    vecs[2]  = '{1'b0, ALU_ADD,    32'hFFFF_FFFF, 32'd1,       32'd0};
    vecs[3]  = '{1'b1, ALU_SLL,    32'd1,        32'h24,       32'h10};
    vecs[4]  = '{1'b0, ALU_SRL,    32'h8000_0000, 32'd4,       32'h0800_0000};
    vecs[5]  = '{1'b1, ALU_SRA,    32'h8000_0000, 32'h24,      32'hF800_0000};
    vecs[6]  = '{1'b0, ALU_SLT,    32'd1,        32'hFFFF_FFFF, 32'd0};
    vecs[7]  = '{1'b1, ALU_SLTU,   32'd1,        32'hFFFF_FFFF, 32'd1};
    vecs[8]  = '{1'b0, ALU_XOR,    32'hF0F0,     32'hFF00,     32'h0FF0};
    vecs[9]  = '{1'b1, ALU_OR,     32'hF0F0,     32'h0F0F,     32'hFFFF};
    vecs[10] = '{1'b0, ALU_AND,    32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00};
    vecs[11] = '{1'b1, ALU_PASS_B, 32'h1234,     32'hABCD,     32'hABCD};
    vecs[12] = '{1'b0, alu_sel_e'(4'hF), 32'h55,  32'h66,       32'd0};

    rst_n = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
    set_req(1'b0, 1'b1, ALU_ADD, 32'd5, 32'd7);
    set_req(1'b1, 1'b0, ALU_ADD, 32'd0, 32'd0);
    #12;
    check("reset ready0", {31'd0, req0_ready}, 32'd0);
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset rsp_result", rsp_result, 32'd0);
    check("reset rsp_id", {31'd0, rsp_id}, 32'd0);

    // Contention straight out of reset: req0 must win first.
    @(negedge clk);
    rst_n = 1'b1;
    set_req(1'b0, 1'b1, ALU_ADD, 32'd5, 32'd7);
    set_req(1'b1, 1'b1, ALU_SUB, 32'd3, 32'd5);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      expect_grant($sformatf("rr%0d", k), logic'(k % 2),
                   (k % 2 == 0) ? 32'd12 : 32'hFFFF_FFFE);
    end

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      set_req(1'b0, 1'b0, ALU_ADD, 32'd0, 32'd0);
      set_req(1'b1, 1'b0, ALU_ADD, 32'd0, 32'd0);
      set_req(vecs[i].id, 1'b1, vecs[i].sel, vecs[i].a, vecs[i].b);
      expect_grant($sformatf("vec%0d", i), vecs[i].id, vecs[i].exp);
    end

    // Backpressure: hold an SRA result for three cycles, then refill in place.
    @(negedge clk);
    set_req(1'b1, 1'b0, ALU_ADD, 32'd0, 32'd0);
    set_req(1'b0, 1'b1, ALU_SRA, 32'h8000_0000, 32'd4);
    expect_grant("bp load", 1'b0, 32'hF800_0000);
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(1'b0, 1'b1, ALU_ADD, 32'd5, 32'd7);
    set_req(1'b1, 1'b1, ALU_SUB, 32'd3, 32'd5);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check($sformatf("bp%0d ready0", k), {31'd0, req0_ready}, 32'd0);
      check($sformatf("bp%0d ready1", k), {31'd0, req1_ready}, 32'd0);
      @(posedge clk); #1;
      check($sformatf("bp%0d rsp_valid", k), {31'd0, rsp_valid}, 32'd1);
      check($sformatf("bp%0d rsp_result", k), rsp_result, 32'hF800_0000);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    expect_grant("bp release", 1'b1, 32'hFFFF_FFFE);

    // Leave last_grant at 0, then flush must restore req0 priority.
    @(negedge clk);
    expect_grant("pre flush", 1'b0, 32'd12);
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush ready0", {31'd0, req0_ready}, 32'd0);
    check("flush ready1", {31'd0, req1_ready}, 32'd0);
    @(posedge clk); #1;
    check("flush rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    expect_grant("post flush", 1'b0, 32'd12);

    // Asynchronous reset while FULL, mid-cycle.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("arst ready0", {31'd0, req0_ready}, 32'd0);
    check("arst ready1", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_req(1'b0, 1'b1, ALU_SLTU, 32'd1, 32'hFFFF_FFFF);
    set_req(1'b1, 1'b1, ALU_SLT,  32'd1, 32'hFFFF_FFFF);
    expect_grant("arst first", 1'b0, 32'd1);
    @(negedge clk);
    expect_grant("arst second", 1'b1, 32'd0);

    @(negedge clk);
    set_req(1'b0, 1'b0, ALU_ADD, 32'd0, 32'd0);
    set_req(1'b1, 1'b0, ALU_ADD, 32'd0, 32'd0);
    @(posedge clk); #1;
    check("drain rsp_valid", {31'd0, rsp_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
